// File: rtl/detector_pulsacion_if.sv
// detector_pulsacion_if: debounced button level in, classified press events out.
interface detector_pulsacion_if;
  logic entrada_limpia;
  logic presionado;
  logic pulso_corto;
  logic pulso_largo;
  logic repeticion;
  modport master (output entrada_limpia, input presionado, pulso_corto, pulso_largo, repeticion);
  modport slave (input entrada_limpia, output presionado, pulso_corto, pulso_largo, repeticion);
endinterface

// File: rtl/detector_pulsacion.sv
// detector_pulsacion: classifies debounced button presses into short, long and auto-repeat events.
module detector_pulsacion #(
  parameter int unsigned T_LARGO = 50_000_000,
  parameter int unsigned T_REP = 10_000_000,
  parameter bit CON_REPETICION = 1'b1,
  parameter int unsigned ANCHO = 26
) (
  input logic clk,
  input logic reset,
  detector_pulsacion_if.slave bus
);
  typedef enum logic [1:0] {ESPERA, REPOSO, PRESIONADO, LARGO} estado_t;
  localparam logic [ANCHO-1:0] LIM_LARGO = ANCHO'(T_LARGO);
  localparam logic [ANCHO-1:0] LIM_REP = ANCHO'(T_REP);
  estado_t estado_q, estado_d;
  logic [ANCHO-1:0] contador_q, contador_d, contador_inc;
  logic presionado_q, presionado_d;
  logic pulso_corto_q, pulso_corto_d;
  logic pulso_largo_q, pulso_largo_d;
  logic repeticion_q, repeticion_d;
  logic alto, fin_largo, fin_rep;
  assign alto = bus.entrada_limpia;
  assign contador_inc = contador_q + ANCHO'(1);
  assign fin_largo = contador_inc == LIM_LARGO;
  assign fin_rep = contador_inc == LIM_REP;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q <= ESPERA;
      contador_q <= '0;
      presionado_q <= 1'b0;
      pulso_corto_q <= 1'b0;
      pulso_largo_q <= 1'b0;
      repeticion_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      contador_q <= contador_d;
      presionado_q <= presionado_d;
      pulso_corto_q <= pulso_corto_d;
      pulso_largo_q <= pulso_largo_d;
      repeticion_q <= repeticion_d;
    end
  end
  // The counter restarts on every wrap, so it stays below max(T_LARGO, T_REP) on an endless hold.
  always_comb begin
    estado_d = estado_q;
    contador_d = '0;
    case (estado_q)
      ESPERA: estado_d = alto ? ESPERA : REPOSO;
      REPOSO: begin
        estado_d = alto ? PRESIONADO : REPOSO;
        contador_d = alto ? ANCHO'(1) : '0;
      end
      PRESIONADO: begin
        estado_d = !alto ? REPOSO : fin_largo ? LARGO : PRESIONADO;
        contador_d = (alto && !fin_largo) ? contador_inc : '0;
      end
      default: begin
        estado_d = alto ? LARGO : REPOSO;
        contador_d = (alto && !fin_rep) ? contador_inc : '0;
      end
    endcase
  end
  always_comb begin
    presionado_d = (estado_q != ESPERA) && alto;
    pulso_corto_d = (estado_q == PRESIONADO) && !alto;
    pulso_largo_d = (estado_q == PRESIONADO) && alto && fin_largo;
    repeticion_d = CON_REPETICION && (estado_q == LARGO) && alto && fin_rep;
  end
  assign bus.presionado = presionado_q;
  assign bus.pulso_corto = pulso_corto_q;
  assign bus.pulso_largo = pulso_largo_q;
  assign bus.repeticion = repeticion_q;
endmodule

// File: tb/tb_detector_pulsacion.sv
// tb_detector_pulsacion: scoreboard bench; expected events are timestamped by edge number.
module tb_detector_pulsacion;
  localparam int TL = 10;
  localparam int TR = 4;
  localparam logic [2:0] K_CORTO = 3'b001;
  localparam logic [2:0] K_LARGO = 3'b010;
  localparam logic [2:0] K_REP = 3'b100;
  typedef struct packed {
    logic [2:0] k;
    logic [31:0] c;
  } ev_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int cyc = 0;
  int pres = 0;
  int total = 0;
  int bad = 0;
  int rd = 0;
  int rd2 = 0;
  ev_t obs_q[$];
  ev_t obs2_q[$];
  ev_t exp_q[$];
  ev_t exp2_q[$];
  ev_t none = '1;
  ev_t e, o;
  always #5 clk = ~clk;
  detector_pulsacion_if bus ();
  detector_pulsacion_if bus2 ();
  assign bus2.entrada_limpia = bus.entrada_limpia;
  detector_pulsacion #(.T_LARGO(TL), .T_REP(TR), .CON_REPETICION(1'b1), .ANCHO(8)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  detector_pulsacion #(.T_LARGO(TL), .T_REP(TR), .CON_REPETICION(1'b0), .ANCHO(8)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2));
  always @(posedge clk) cyc <= cyc + 1;
  // Pulses seen after edge number cyc are logged with that edge number.
  always @(negedge clk) begin
    if (bus.pulso_corto | bus.pulso_largo | bus.repeticion)
      obs_q.push_back(ev_t'({bus.repeticion, bus.pulso_largo, bus.pulso_corto, 32'(cyc)}));
    if (bus2.pulso_corto | bus2.pulso_largo | bus2.repeticion)
      obs2_q.push_back(ev_t'({bus2.repeticion, bus2.pulso_largo, bus2.pulso_corto, 32'(cyc)}));
    if (bus.presionado) pres++;
  end
  task automatic drive(input logic v, input int n);
    repeat (n) begin
      bus.entrada_limpia = v;
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_reset;
    int p0;
    bus.entrada_limpia = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.presionado, bus.pulso_corto, bus.pulso_largo, bus.repeticion} !== 4'b0) begin
      bad++;
      $display("FAIL reset_outs got=%b want=0000", {bus.presionado, bus.pulso_corto, bus.pulso_largo, bus.repeticion});
    end
    reset = 1'b1;
    p0 = pres;
    drive(1'b0, 20);
    total++;
    if (pres - p0 !== 0) begin bad++; $display("FAIL idle_pres got=%0d want=0", pres - p0); end
    while (exp_q.size() > 0 || rd < obs_q.size()) begin
      e = exp_q.size() > 0 ? exp_q.pop_front() : none;
      o = none;
      if (rd < obs_q.size()) begin o = obs_q[rd]; rd++; end
      total++;
      if (o !== e) begin bad++; $display("FAIL idle_ev got k=%b c=%0d want k=%b c=%0d", o.k, o.c, e.k, e.c); end
    end
  endtask
  task automatic test_short;
    int s, p0;
    s = cyc + 1;
    p0 = pres;
    exp_q.push_back(ev_t'({K_CORTO, 32'(s + 5)}));
    drive(1'b1, 5);
    drive(1'b0, 3);
    total++;
    if (pres - p0 !== 5) begin bad++; $display("FAIL short_pres got=%0d want=5", pres - p0); end
    while (exp_q.size() > 0 || rd < obs_q.size()) begin
      e = exp_q.size() > 0 ? exp_q.pop_front() : none;
      o = none;
      if (rd < obs_q.size()) begin o = obs_q[rd]; rd++; end
      total++;
      if (o !== e) begin bad++; $display("FAIL short_ev got k=%b c=%0d want k=%b c=%0d", o.k, o.c, e.k, e.c); end
    end
  endtask
  task automatic test_boundary;
    int s, p0;
    s = cyc + 1;
    p0 = pres;
    exp_q.push_back(ev_t'({K_CORTO, 32'(s + TL - 1)}));
    drive(1'b1, TL - 1);
    drive(1'b0, 3);
    total++;
    if (pres - p0 !== TL - 1) begin bad++; $display("FAIL bound9_pres got=%0d want=%0d", pres - p0, TL - 1); end
    s = cyc + 1;
    p0 = pres;
    exp_q.push_back(ev_t'({K_LARGO, 32'(s + TL - 1)}));
    drive(1'b1, TL);
    drive(1'b0, 3);
    total++;
    if (pres - p0 !== TL) begin bad++; $display("FAIL bound10_pres got=%0d want=%0d", pres - p0, TL); end
    while (exp_q.size() > 0 || rd < obs_q.size()) begin
      e = exp_q.size() > 0 ? exp_q.pop_front() : none;
      o = none;
      if (rd < obs_q.size()) begin o = obs_q[rd]; rd++; end
      total++;
      if (o !== e) begin bad++; $display("FAIL bound_ev got k=%b c=%0d want k=%b c=%0d", o.k, o.c, e.k, e.c); end
    end
  endtask
  task automatic test_repeat;
    int s, p0;
    rd2 = obs2_q.size();
    s = cyc + 1;
    p0 = pres;
    exp_q.push_back(ev_t'({K_LARGO, 32'(s + TL - 1)}));
    for (int k = 1; k <= 3; k++) exp_q.push_back(ev_t'({K_REP, 32'(s + TL - 1 + k * TR)}));
    exp2_q.push_back(ev_t'({K_LARGO, 32'(s + TL - 1)}));
    drive(1'b1, 22);
    drive(1'b0, 3);
    total++;
    if (pres - p0 !== 22) begin bad++; $display("FAIL rep_pres got=%0d want=22", pres - p0); end
    while (exp_q.size() > 0 || rd < obs_q.size()) begin
      e = exp_q.size() > 0 ? exp_q.pop_front() : none;
      o = none;
      if (rd < obs_q.size()) begin o = obs_q[rd]; rd++; end
      total++;
      if (o !== e) begin bad++; $display("FAIL rep_ev got k=%b c=%0d want k=%b c=%0d", o.k, o.c, e.k, e.c); end
    end
    while (exp2_q.size() > 0 || rd2 < obs2_q.size()) begin
      e = exp2_q.size() > 0 ? exp2_q.pop_front() : none;
      o = none;
      if (rd2 < obs2_q.size()) begin o = obs2_q[rd2]; rd2++; end
      total++;
      if (o !== e) begin bad++; $display("FAIL norep_ev got k=%b c=%0d want k=%b c=%0d", o.k, o.c, e.k, e.c); end
    end
  endtask
  task automatic test_reset_held;
    int s, p0;
    drive(1'b1, 7);
    reset = 1'b0;
    #1;
    total++;
    if ({bus.presionado, bus.pulso_corto, bus.pulso_largo, bus.repeticion} !== 4'b0) begin
      bad++;
      $display("FAIL async_reset got=%b want=0000", {bus.presionado, bus.pulso_corto, bus.pulso_largo, bus.repeticion});
    end
    drive(1'b1, 2);
    reset = 1'b1;
    p0 = pres;
    drive(1'b1, 30);
    total++;
    if (pres - p0 !== 0) begin bad++; $display("FAIL held_pres got=%0d want=0", pres - p0); end
    s = cyc + 1;
    p0 = pres;
    exp_q.push_back(ev_t'({K_CORTO, 32'(s + 4)}));
    drive(1'b0, 1);
    drive(1'b1, 3);
    drive(1'b0, 3);
    total++;
    if (pres - p0 !== 3) begin bad++; $display("FAIL after_held_pres got=%0d want=3", pres - p0); end
    while (exp_q.size() > 0 || rd < obs_q.size()) begin
      e = exp_q.size() > 0 ? exp_q.pop_front() : none;
      o = none;
      if (rd < obs_q.size()) begin o = obs_q[rd]; rd++; end
      total++;
      if (o !== e) begin bad++; $display("FAIL held_ev got k=%b c=%0d want k=%b c=%0d", o.k, o.c, e.k, e.c); end
    end
  endtask
  task automatic test_back_to_back;
    int s, p0;
    s = cyc + 1;
    p0 = pres;
    exp_q.push_back(ev_t'({K_CORTO, 32'(s + 3)}));
    exp_q.push_back(ev_t'({K_CORTO, 32'(s + 7)}));
    drive(1'b1, 3);
    drive(1'b0, 1);
    drive(1'b1, 3);
    drive(1'b0, 3);
    total++;
    if (pres - p0 !== 6) begin bad++; $display("FAIL b2b_pres got=%0d want=6", pres - p0); end
    while (exp_q.size() > 0 || rd < obs_q.size()) begin
      e = exp_q.size() > 0 ? exp_q.pop_front() : none;
      o = none;
      if (rd < obs_q.size()) begin o = obs_q[rd]; rd++; end
      total++;
      if (o !== e) begin bad++; $display("FAIL b2b_ev got k=%b c=%0d want k=%b c=%0d", o.k, o.c, e.k, e.c); end
    end
  endtask
  initial begin
    test_reset;
    test_short;
    test_boundary;
    test_repeat;
    test_reset_held;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
